// File: rtl/decimal_entry_if.sv
// Keypad-to-converter bundle: key handshake in, BCD echo and converted binary result out.
// dbg_state mirrors the converter FSM so checkers can bind to it without reaching inside.
interface decimal_entry_if #(
    parameter int NUMBER_WIDTH = 16
);
    // ceil(NUMBER_WIDTH * log10(2)) in integer arithmetic
    localparam int DIGITS_COUNT = (NUMBER_WIDTH * 301030 + 999999) / 1000000;
    localparam int COUNT_W      = $clog2(DIGITS_COUNT + 1);

    // key_valid/key_code are held by the producer until key_valid && key_ready at a rising edge;
    // that edge is the only point where a key is consumed.
    logic                      key_valid;
    logic                      key_ready;
    logic [3:0]                key_code;
    logic [4*DIGITS_COUNT-1:0] digits;
    logic [COUNT_W-1:0]        digit_count;
    logic [NUMBER_WIDTH-1:0]   value;
    logic                      value_valid;
    logic                      overflow;
    logic [1:0]                dbg_state;

    modport master (
        output key_valid, key_code,
        input  key_ready, digits, digit_count, value, value_valid, overflow, dbg_state
    );

    modport slave (
        input  key_valid, key_code,
        output key_ready, digits, digit_count, value, value_valid, overflow, dbg_state
    );
endinterface

// File: rtl/decimal_entry.sv
// Decimal keypad entry: editable BCD buffer, converted to binary one digit per cycle on ENTER.
// Result saturates to all-ones with overflow set when the entry exceeds NUMBER_WIDTH bits.
module decimal_entry #(
    parameter int NUMBER_WIDTH = 16
) (
    input logic           clk,
    input logic           rst,
    decimal_entry_if.slave bus
);
    localparam int DIGITS_COUNT = (NUMBER_WIDTH * 301030 + 999999) / 1000000;
    localparam int COUNT_W      = $clog2(DIGITS_COUNT + 1);
    localparam int DIG_W        = 4 * DIGITS_COUNT;
    localparam int ACC_W        = NUMBER_WIDTH + 4;

    localparam logic [ACC_W-1:0]   MAX_VAL   = {4'b0000, {NUMBER_WIDTH{1'b1}}};
    localparam logic [COUNT_W-1:0] FULL_CNT  = COUNT_W'(DIGITS_COUNT);
    localparam logic [COUNT_W-1:0] LAST_IDX  = COUNT_W'(DIGITS_COUNT - 1);
    localparam logic [3:0]         KEY_BS    = 4'd10;
    localparam logic [3:0]         KEY_CLR   = 4'd11;
    localparam logic [3:0]         KEY_ENTER = 4'd12;

    typedef enum logic [1:0] {
        S_ENTRY   = 2'd0,
        S_CONVERT = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [DIG_W-1:0]     digits_q, digits_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [COUNT_W-1:0]   idx_q, idx_d;
    logic                 ovf_q, ovf_d;
    logic [NUMBER_WIDTH-1:0] value_q, value_d;
    logic                 overflow_q, overflow_d;
    logic                 value_valid_q, value_valid_d;

    logic                 key_ready;
    logic                 key_accept;
    logic [3:0]           cur_digit;
    logic [ACC_W-1:0]     acc_next;

    assign key_accept = bus.key_valid && key_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_ENTRY;
            digits_q      <= '0;
            count_q       <= '0;
            acc_q         <= '0;
            idx_q         <= '0;
            ovf_q         <= 1'b0;
            value_q       <= '0;
            overflow_q    <= 1'b0;
            value_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            digits_q      <= digits_d;
            count_q       <= count_d;
            acc_q         <= acc_d;
            idx_q         <= idx_d;
            ovf_q         <= ovf_d;
            value_q       <= value_d;
            overflow_q    <= overflow_d;
            value_valid_q <= value_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ENTRY:   if (key_accept && bus.key_code == KEY_ENTER) state_d = S_CONVERT;
            S_CONVERT: if (idx_q == '0) state_d = S_DONE;
            S_DONE:    state_d = S_ENTRY;
            default:   state_d = S_ENTRY;
        endcase
    end

    always_comb begin
        key_ready = (state_q == S_ENTRY);
    end

    // Most significant slot first; unfilled leading slots hold zero.
    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < DIGITS_COUNT; i++) begin
            if (idx_q == COUNT_W'(i)) cur_digit = digits_q[4*i +: 4];
        end
    end

    assign acc_next = (acc_q << 3) + (acc_q << 1) + ACC_W'(cur_digit);

    always_comb begin
        digits_d      = digits_q;
        count_d       = count_q;
        acc_d         = acc_q;
        idx_d         = idx_q;
        ovf_d         = ovf_q;
        value_d       = value_q;
        overflow_d    = overflow_q;
        value_valid_d = 1'b0;
        case (state_q)
            S_ENTRY: begin
                if (key_accept) begin
                    if (bus.key_code <= 4'd9) begin
                        if (count_q < FULL_CNT) begin
                            digits_d = (digits_q << 4) | DIG_W'(bus.key_code);
                            count_d  = count_q + 1'b1;
                        end
                    end else if (bus.key_code == KEY_BS) begin
                        if (count_q != '0) begin
                            digits_d = digits_q >> 4;
                            count_d  = count_q - 1'b1;
                        end
                    end else if (bus.key_code == KEY_CLR) begin
                        digits_d = '0;
                        count_d  = '0;
                    end else if (bus.key_code == KEY_ENTER) begin
                        acc_d = '0;
                        idx_d = LAST_IDX;
                        ovf_d = 1'b0;
                    end
                end
            end
            S_CONVERT: begin
                // Once ovf is set acc may wrap; the value is discarded by saturation anyway.
                acc_d = acc_next;
                ovf_d = ovf_q | (acc_next > MAX_VAL);
                idx_d = idx_q - 1'b1;
            end
            S_DONE: begin
                value_d       = ovf_q ? '1 : acc_q[NUMBER_WIDTH-1:0];
                overflow_d    = ovf_q;
                value_valid_d = 1'b1;
                digits_d      = '0;
                count_d       = '0;
            end
            default: ;
        endcase
    end

    assign bus.key_ready   = key_ready;
    assign bus.digits      = digits_q;
    assign bus.digit_count = count_q;
    assign bus.value       = value_q;
    assign bus.value_valid = value_valid_q;
    assign bus.overflow    = overflow_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_decimal_entry.sv
// Bench for decimal_entry: directed keypad scenarios plus random key streams,
// checked against a digit-list model that converts with plain integer arithmetic.
module tb_decimal_entry;
    localparam int NW = 16;
    localparam int DC = 5;
    localparam longint MAXV = (64'd1 << NW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    decimal_entry_if #(.NUMBER_WIDTH(NW)) bus ();
    decimal_entry #(.NUMBER_WIDTH(NW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Model state: entered digits in order, expected results awaiting value_valid.
    int unsigned      mdl_digits[$];
    logic [NW-1:0]    exp_q[$];
    logic             exp_ovf_q[$];
    logic [NW-1:0]    held_value = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mdl_echo();
        logic [31:0] e = '0;
        foreach (mdl_digits[i]) e = (e << 4) | 32'(mdl_digits[i]);
        return e;
    endfunction

    task automatic model_key(input logic [3:0] code);
        longint v;
        if (code <= 4'd9) begin
            if (mdl_digits.size() < DC) mdl_digits.push_back(int'(code));
        end else if (code == 4'd10) begin
            if (mdl_digits.size() > 0) void'(mdl_digits.pop_back());
        end else if (code == 4'd11) begin
            mdl_digits.delete();
        end else if (code == 4'd12) begin
            v = 0;
            foreach (mdl_digits[i]) v = v * 10 + longint'(mdl_digits[i]);
            exp_ovf_q.push_back(v > MAXV);
            exp_q.push_back((v > MAXV) ? {NW{1'b1}} : v[NW-1:0]);
            mdl_digits.delete();
        end
    endtask

    task automatic press(input logic [3:0] code);
        int n = 0;
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        while (!bus.key_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("key_ready_before_accept", 32'(bus.key_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        model_key(code);
    endtask

    task automatic check_echo(input string tag);
        check({tag, "_digits"}, 32'(bus.digits), mdl_echo());
        check({tag, "_count"}, 32'(bus.digit_count), 32'(mdl_digits.size()));
    endtask

    // Call right after ENTER has been accepted.
    task automatic wait_result(input string tag);
        int n = 0;
        logic [NW-1:0] ev;
        logic          eo;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.value_valid) break;
        end
        check({tag, "_latency"}, 32'(n), 32'(DC + 1));
        ev = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        eo = (exp_ovf_q.size() > 0) ? exp_ovf_q.pop_front() : 1'bx;
        held_value = ev;
        check({tag, "_value"}, 32'(bus.value), 32'(ev));
        check({tag, "_overflow"}, 32'(bus.overflow), 32'(eo));
        check({tag, "_cleared_digits"}, 32'(bus.digits), 32'd0);
        check({tag, "_cleared_count"}, 32'(bus.digit_count), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_vv_pulse"}, 32'(bus.value_valid), 32'd0);
        check({tag, "_value_held"}, 32'(bus.value), 32'(held_value));
    endtask

    task automatic press_seq(input logic [3:0] seq[$]);
        foreach (seq[i]) press(seq[i]);
    endtask

    initial begin
        logic [3:0] seq[$];
        int n;
        int len;
        int r;

        bus.key_valid = 1'b0;
        bus.key_code  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_value", 32'(bus.value), 32'd0);
        check("rst_digits", 32'(bus.digits), 32'd0);
        check("rst_count", 32'(bus.digit_count), 32'd0);
        check("rst_vv", 32'(bus.value_valid), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_ready", 32'(bus.key_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("idle_vv", 32'(bus.value_valid), 32'd0);
        end

        seq = '{4'd6, 4'd5, 4'd5, 4'd3, 4'd5};
        press_seq(seq);
        check_echo("max_echo");
        press(4'd12);
        wait_result("max");

        seq = '{4'd6, 4'd5, 4'd5, 4'd3, 4'd6};
        press_seq(seq);
        press(4'd12);
        wait_result("max_plus1");

        seq = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        press_seq(seq);
        press(4'd12);
        wait_result("nines");

        seq = '{4'd1, 4'd2, 4'd3, 4'd10, 4'd4};
        press_seq(seq);
        check_echo("bs_echo");
        press(4'd12);
        wait_result("bs");
        press(4'd10);
        check_echo("bs_empty");
        press(4'd12);
        wait_result("empty");

        seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7};
        press_seq(seq);
        check("full_echo_digits", 32'(bus.digits), 32'h12345);
        check_echo("full");
        press(4'd12);
        wait_result("full");

        // Key held through the conversion must stall and land after DONE.
        seq = '{4'd4, 4'd2};
        press_seq(seq);
        press(4'd12);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'd8;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.value_valid) break;
            check("stall_ready_low", 32'(bus.key_ready), 32'd0);
        end
        check("stall_latency", 32'(n), 32'(DC + 1));
        held_value = exp_q.pop_front();
        void'(exp_ovf_q.pop_front());
        check("stall_value", 32'(bus.value), 32'(held_value));
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        model_key(4'd8);
        check("stall_digits", 32'(bus.digits), 32'h8);
        check_echo("stall");
        press(4'd11);
        check_echo("clear");

        // Reset in the middle of a conversion.
        seq = '{4'd1, 4'd2};
        press_seq(seq);
        press(4'd12);
        void'(exp_q.pop_back());
        void'(exp_ovf_q.pop_back());
        repeat (2) begin
            @(posedge clk);
            #1;
            check("abort_vv_pre", 32'(bus.value_valid), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        held_value = '0;
        check("abort_vv", 32'(bus.value_valid), 32'd0);
        check("abort_value", 32'(bus.value), 32'd0);
        check("abort_ready", 32'(bus.key_ready), 32'd1);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_vv", 32'(bus.value_valid), 32'd0);
        end
        check("abort_value_after", 32'(bus.value), 32'd0);

        for (int t = 0; t < 40; t++) begin
            len = $urandom_range(0, 8);
            for (int k = 0; k < len; k++) begin
                r = $urandom_range(0, 99);
                if (r < 70)      press(4'($urandom_range(0, 9)));
                else if (r < 80) press(4'd10);
                else if (r < 85) press(4'd11);
                else             press(4'($urandom_range(13, 15)));
            end
            check_echo("rand_echo");
            press(4'd12);
            wait_result("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
